// File: rtl/sw_debounce.sv
// Per-channel switch debouncer: two-flop synchronizer, stability counter,
// registered level / change-pulse / sticky-change outputs.
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             io_mainClk,
    input  logic             io_asyncReset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed,
    output logic [WIDTH-1:0] sw_sticky,
    input  logic [WIDTH-1:0] sw_clear
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q,  stable_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] sticky_q,  sticky_d;
    logic [WIDTH-1:0] accept;

    // A channel accepts its new level once the synchronized input has
    // disagreed with the stable level for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]  = '0;
                accept[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        stable_d  = stable_q ^ accept;
        changed_d = accept;
        // A newly accepted change outranks a coincident clear.
        sticky_d  = accept | (sticky_q & ~sw_clear);
    end

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            changed_q <= '0;
            sticky_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            sticky_q  <= sticky_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable  = stable_q;
    assign sw_changed = changed_q;
    assign sw_sticky  = sticky_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (WIDTH=8, DEBOUNCE_CYCLES=4): vector table,
// directed corner sequences and random stimulus against a window model.
module tb_sw_debounce;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int MAXE = 2048;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clear;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_changed;
    logic [W-1:0] sw_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .io_mainClk   (clk),
        .io_asyncReset(rst),
        .sw_raw       (sw_raw),
        .sw_stable    (sw_stable),
        .sw_changed   (sw_changed),
        .sw_sticky    (sw_sticky),
        .sw_clear     (sw_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: raw level sampled at each post-reset edge; a bit is accepted
    // when the last D synchronized samples (raw delayed two edges) all
    // differ from the stable level and none precede its previous acceptance.
    logic [W-1:0] raw_at [0:MAXE];
    int           e;
    int           last_acc [W];
    logic [W-1:0] m_stable, m_changed, m_sticky;

    function automatic logic [W-1:0] s2(input int k);
        return (k - 2 >= 1) ? raw_at[k-2] : '0;
    endfunction

    task automatic model_clear();
        e = 0;
        m_stable = '0; m_changed = '0; m_sticky = '0;
        for (int i = 0; i < W; i++) last_acc[i] = 0;
        for (int k = 0; k <= MAXE; k++) raw_at[k] = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] raw, input logic [W-1:0] clr);
        logic [W-1:0] acc;
        logic [W-1:0] v;
        logic         ok;
        acc = '0;
        if (e < MAXE) e++;
        raw_at[e] = raw;
        for (int i = 0; i < W; i++) begin
            if (e - last_acc[i] >= D) begin
                ok = 1'b1;
                for (int j = e - D + 1; j <= e; j++) begin
                    v = s2(j);
                    if (v[i] == m_stable[i]) ok = 1'b0;
                end
                if (ok) begin
                    acc[i] = 1'b1;
                    last_acc[i] = e;
                end
            end
        end
        m_changed = acc;
        m_stable  = m_stable ^ acc;
        m_sticky  = acc | (m_sticky & ~clr);
    endtask

    task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        else n_pass++;
    endtask

    // Drive one cycle of inputs, advance one edge, compare against the model.
    task automatic step(input logic [W-1:0] raw, input logic [W-1:0] clr);
        sw_raw   = raw;
        sw_clear = clr;
        @(posedge clk);
        model_edge(raw, clr);
        #1;
        check8("model_stable",  sw_stable,  m_stable);
        check8("model_changed", sw_changed, m_changed);
        check8("model_sticky",  sw_sticky,  m_sticky);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check8("rst_stable",  sw_stable,  '0);
        check8("rst_changed", sw_changed, '0);
        check8("rst_sticky",  sw_sticky,  '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] clr;
        logic [W-1:0] st;
        logic [W-1:0] ch;
        logic [W-1:0] sk;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int           pulses;
        int           pulse_at;
        logic [W-1:0] r;
        logic [W-1:0] c;

        // Acceptance of bit 0 at edge 6, sticky clear, then release back to 0.
        for (int i = 0; i < 5; i++) tbl[i] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01};
        tbl[6]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
        tbl[7]  = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        tbl[8]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
        for (int i = 9; i < 14; i++) tbl[i] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        tbl[14] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        tbl[15] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00};

        sw_raw = '0;
        sw_clear = '0;
        rst = 1'b0;
        model_clear();
        #2;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].raw, tbl[i].clr);
            check8("tbl_stable",  sw_stable,  tbl[i].st);
            check8("tbl_changed", sw_changed, tbl[i].ch);
            check8("tbl_sticky",  sw_sticky,  tbl[i].sk);
        end

        // Glitch on bit 2 shorter than the debounce window.
        for (int k = 0; k < 11; k++) begin
            step((k < 3) ? 8'h04 : 8'h00, 8'h00);
            check8("glitch_stable",  sw_stable,  8'h00);
            check8("glitch_changed", sw_changed, 8'h00);
            check8("glitch_sticky",  sw_sticky,  8'h00);
        end

        // Bounce on bit 0, then held high from step 20.
        pulses = 0;
        pulse_at = -1;
        for (int k = 0; k < 32; k++) begin
            r = (k >= 20) ? 8'h01 : (((k / 2) % 2 == 0) ? 8'h01 : 8'h00);
            step(r, 8'h00);
            if (sw_changed[0]) begin
                pulses++;
                pulse_at = k;
            end
        end
        check_int("bounce_pulses", pulses, 1);
        check_int("bounce_pulse_step", pulse_at, 25);

        // Bit 1 accepted on the same edge that clears bits 0 and 1.
        for (int k = 0; k < 5; k++) step(8'h03, 8'h00);
        step(8'h03, 8'h03);
        check8("coinc_changed", sw_changed, 8'h02);
        check8("coinc_sticky",  sw_sticky,  8'h02);
        check8("coinc_stable",  sw_stable,  8'h03);
        step(8'h03, 8'h00);
        check8("coinc_sticky_hold", sw_sticky, 8'h02);

        // Bits 3 and 7 change together.
        for (int k = 0; k < 6; k++) begin
            step(8'h8B, 8'h00);
            if (k < 5) check8("par_wait_stable", sw_stable, 8'h03);
        end
        check8("par_stable",  sw_stable,  8'h8B);
        check8("par_changed", sw_changed, 8'h88);
        check8("par_sticky",  sw_sticky,  8'h8A);

        // Reset in the middle of a count, then re-acceptance of 0xFF.
        for (int k = 0; k < 3; k++) step(8'hFF, 8'h00);
        #2;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(8'hFF, 8'h00);
            if (k < 5) check8("post_rst_wait", sw_stable, 8'h00);
            if (k == 5) begin
                check8("post_rst_stable",  sw_stable,  8'hFF);
                check8("post_rst_changed", sw_changed, 8'hFF);
                check8("post_rst_sticky",  sw_sticky,  8'hFF);
            end
            if (k == 6) check8("post_rst_pulse_end", sw_changed, 8'h00);
        end

        // Random bouncing and clears against the model, one reset midway.
        #2;
        do_reset();
        r = '0;
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) begin
                #2;
                do_reset();
            end
            c = '0;
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
                if ($urandom_range(0, 3) == 0) c[i] = 1'b1;
            end
            step(r, c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
